// File: rtl/pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_pkg : shared encodings and bundle widths for the elastic pipeline stages
// Rev 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_BUSY  = ST_BUSY,
        S_FULL  = ST_FULL
    } state_t;

    localparam int IDEX_DATA_W  = 128;
    localparam int IDEX_CTRL_W  = 5;
    localparam int EXMEM_DATA_W = 101;
    localparam int EXMEM_CTRL_W = 5;
    localparam int MEMWB_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 5;

    localparam int CTRL_REG_WRITE    = 0;
    localparam int CTRL_MEM_READ     = 1;
    localparam int CTRL_MEM_WRITE    = 2;
    localparam int CTRL_MEM_TO_REG   = 3;
    localparam int CTRL_BRANCH_TAKEN = 4;

    function automatic logic [1:0] occupancy_of(input state_t s);
        case (s)
            S_BUSY:  return 2'd1;
            S_FULL:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones; cleared only by reset
// Rev 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_skid_stage : valid/ready pipeline register with a 2-entry skid, flush,
//                   bubble control gating and a saturating stall counter
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_push;
    logic w_pop;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_load_main_in = 1'b1;
                        w_next_state   = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_push && w_pop) begin
                        w_load_main_in = 1'b1;
                    end else if (w_push) begin
                        w_load_skid  = 1'b1;
                        w_next_state = S_FULL;
                    end else if (w_pop) begin
                        w_next_state = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_load_main_skid = 1'b1;
                        w_next_state     = S_BUSY;
                    end
                end
                default: w_next_state = S_EMPTY;
            endcase
        end
    end

    // in_ready is its own flop so it reads 0 throughout reset and never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != S_FULL);
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_valid & ~r_in_ready & ~flush),
        .count (stall_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main_data;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign occupancy = occupancy_of(r_state);

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_skid_stage : directed + random bench against a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int DW = 101;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          flush;

    logic          in_ready,  in_ready_s;
    logic          out_valid, out_valid_s;
    logic [DW-1:0] out_data,  out_data_s;
    logic [CW-1:0] out_ctrl,  out_ctrl_s;
    logic [1:0]    occupancy, occupancy_s;
    logic [15:0]   stall_cnt;
    logic [2:0]    stall_cnt_s;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    // Same stimulus, narrow counter to reach saturation quickly.
    pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dut_s (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_ctrl(out_ctrl_s),
        .flush(flush), .occupancy(occupancy_s), .stall_cnt(stall_cnt_s)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t   q[$];
    bit      rst_last = 1'b1;
    longint  stall_m  = 0;
    int      n_tests  = 0;
    int      n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in_ready();
        return !rst_last && (q.size() < 2);
    endfunction

    // Behavioural rule set: a bounded FIFO of two beats, flush empties it.
    task automatic model_update(input bit r, input bit iv, input beat_t b,
                                input bit ordy, input bit fl);
        bit rdy;
        rdy = m_in_ready();
        if (r) begin
            q.delete();
            stall_m  = 0;
            rst_last = 1'b1;
        end else begin
            rst_last = 1'b0;
            if (fl) begin
                q.delete();
            end else begin
                if (iv && !rdy) stall_m++;
                if (q.size() > 0 && ordy) void'(q.pop_front());
                if (iv && rdy) q.push_back(b);
            end
        end
    endtask

    task automatic check_all();
        logic [127:0] exp_ctrl;
        longint       s16, s3;
        exp_ctrl = (q.size() > 0) ? 128'(q[0].c) : 128'd0;
        s16 = (stall_m > 65535) ? 65535 : stall_m;
        s3  = (stall_m > 7) ? 7 : stall_m;
        chk("in_ready",    128'(in_ready),  128'(m_in_ready()));
        chk("out_valid",   128'(out_valid), 128'(q.size() > 0));
        chk("out_ctrl",    128'(out_ctrl),  exp_ctrl);
        chk("occupancy",   128'(occupancy), 128'(q.size()));
        chk("stall_cnt",   128'(stall_cnt), 128'(s16));
        chk("stall_cnt_s", 128'(stall_cnt_s), 128'(s3));
        chk("occupancy_s", 128'(occupancy_s), 128'(q.size()));
        if (q.size() > 0) chk("out_data", 128'(out_data), 128'(q[0].d));
    endtask

    task automatic step(input bit r, input bit iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input bit ordy, input bit fl);
        beat_t b;
        rst = r; in_valid = iv; in_data = d; in_ctrl = c;
        out_ready = ordy; flush = fl;
        b.d = d; b.c = c;
        @(posedge clk);
        model_update(r, iv, b, ordy, fl);
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0;

        // Reset, then stream three beats with the sink always ready
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        step(0, 0, 0, 0, 1, 0);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);
        step(0, 1, 'h11, 5'h01, 1, 0);
        chk("stream_11", 128'(out_data), 128'h11);
        step(0, 1, 'h22, 5'h02, 1, 0);
        chk("stream_22", 128'(out_data), 128'h22);
        step(0, 1, 'h33, 5'h03, 1, 0);
        chk("stream_33", 128'(out_data), 128'h33);
        chk("stream_occ", 128'(occupancy), 128'd1);
        chk("stream_stall", 128'(stall_cnt), 128'd0);
        step(0, 0, 0, 0, 1, 0);

        // Back-pressure into the skid, then drain
        step(0, 1, 'hA, 5'h0A, 0, 0);
        step(0, 1, 'hB, 5'h0B, 0, 0);
        chk("bp_occ", 128'(occupancy), 128'd2);
        chk("bp_ready", 128'(in_ready), 128'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 'hD, 5'h0D, 0, 0);
        chk("bp_stall", 128'(stall_cnt), 128'd3);
        chk("bp_head_a", 128'(out_data), 128'hA);
        step(0, 0, 0, 0, 1, 0);
        chk("bp_head_b", 128'(out_data), 128'hB);
        chk("bp_ready_back", 128'(in_ready), 128'd1);
        step(0, 0, 0, 0, 1, 0);

        // Flush while full, with a beat offered in the same cycle
        step(0, 1, 'hA, 5'h1F, 0, 0);
        step(0, 1, 'hB, 5'h1F, 0, 0);
        step(0, 1, 'hC, 5'h1F, 0, 1);
        chk("flush_valid", 128'(out_valid), 128'd0);
        chk("flush_ctrl", 128'(out_ctrl), 128'd0);
        chk("flush_occ", 128'(occupancy), 128'd0);
        step(0, 0, 0, 0, 1, 0);

        // Control gating: all-ones ctrl visible for exactly one cycle
        step(0, 1, 'h55, 5'h1F, 1, 0);
        chk("gate_on", 128'(out_ctrl), 128'h1F);
        step(0, 0, 0, 0, 1, 0);
        chk("gate_off", 128'(out_ctrl), 128'd0);
        step(0, 0, 0, 0, 1, 0);

        // Saturation of the narrow counter, immune to flush, cleared by reset
        step(0, 1, 'h1, 5'h01, 0, 0);
        step(0, 1, 'h2, 5'h02, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 'h3, 5'h03, 0, 0);
        chk("sat_hold", 128'(stall_cnt_s), 128'd7);
        step(0, 0, 0, 0, 0, 1);
        chk("sat_flush", 128'(stall_cnt_s), 128'd7);
        step(1, 0, 0, 0, 0, 0);
        chk("sat_reset", 128'(stall_cnt_s), 128'd0);
        step(0, 0, 0, 0, 0, 0);

        // Reset in FULL with the sink ready
        step(0, 1, 'h7, 5'h1F, 0, 0);
        step(0, 1, 'h8, 5'h1F, 0, 0);
        step(0, 1, 'h9, 5'h1F, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("mid_rst_occ", 128'(occupancy), 128'd0);
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_ctrl", 128'(out_ctrl), 128'd0);
        chk("mid_rst_stall", 128'(stall_cnt), 128'd0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("mid_rst_after", 128'(out_valid), 128'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7),
                 rand_data(),
                 CW'($urandom),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
